// File: rtl/shtp_report_parser.sv
// BNO08X SHTP packet/report parser: walks the sensor reports on CHANNEL and emits one record per forwarded report.
// Optional sequence-gap checking is enabled by defining SHTP_SEQ_CHECK_EN; otherwise seq_err is tied low.
module shtp_report_parser #(
  parameter logic [7:0]  CHANNEL  = 8'd3,
  parameter logic [15:0] FWD_MASK = 16'h0124,
  parameter int unsigned MAX_LEN  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       frame_end,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       data_ready,
  output logic [7:0] sensor_report_id,
  output logic [7:0] sensor_data [0:MAX_LEN-1],
  output logic [4:0] sensor_data_len,
  output logic       pkt_err,
  output logic       seq_err
);

  localparam int unsigned IW = $clog2(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_RPT_ID, S_RPT_BODY, S_SKIP} state_t;

  state_t      state, cur_st;
  logic [15:0] byte_cnt, cur_cnt, cnt_inc, pkt_len;
  logic [7:0]  chan, rpt_id;
  logic [4:0]  rpt_idx, rpt_len, id_len;
  logic [7:0]  shadow [0:MAX_LEN-1];
  logic        fwd, rpt_last, pkt_done, byte_leaves, pkt_open;

  // frame_start overrides the registered state so a same-cycle byte is header byte 0
  always_comb begin
    cur_st   = frame_start ? S_HDR : state;
    cur_cnt  = frame_start ? '0 : byte_cnt;
    cnt_inc  = cur_cnt + 16'd1;
    pkt_done = (cnt_inc == pkt_len);
    rpt_last = ((rpt_idx + 5'd1) == rpt_len);
    fwd      = (rpt_id[7:4] == 4'h0) && FWD_MASK[rpt_id[3:0]];
    case (byte_data)
      8'h01, 8'h02, 8'h03: id_len = 5'd10;
      8'h05:               id_len = 5'd14;
      8'h08:               id_len = 5'd12;
      8'hFA, 8'hFB:        id_len = 5'd5;
      default:             id_len = 5'd0;
    endcase
    // byte_leaves: this byte closes the packet (normally or by error), so a same-cycle frame_end is benign
    case (cur_st)
      S_HDR:      byte_leaves = (cur_cnt == 16'd3) && ((pkt_len <= 16'd4) || (chan != CHANNEL));
      S_RPT_ID:   byte_leaves = (id_len == 5'd0) || pkt_done;
      S_RPT_BODY: byte_leaves = pkt_done;
      default:    byte_leaves = 1'b0;
    endcase
    pkt_open = (cur_st == S_HDR) || (cur_st == S_RPT_ID) || (cur_st == S_RPT_BODY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      byte_cnt         <= '0;
      pkt_len          <= '0;
      chan             <= '0;
      rpt_id           <= '0;
      rpt_idx          <= '0;
      rpt_len          <= '0;
      data_ready       <= 1'b0;
      pkt_err          <= 1'b0;
      sensor_report_id <= '0;
      sensor_data_len  <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        sensor_data[i] <= '0;
        shadow[i]      <= '0;
      end
    end else begin
      data_ready <= 1'b0;
      pkt_err    <= 1'b0;
      if (frame_start) begin
        state    <= S_HDR;
        byte_cnt <= '0;
      end
      if (byte_valid) begin
        case (cur_st)
          S_HDR: begin
            byte_cnt <= cnt_inc;
            case (cur_cnt[1:0])
              2'd0: pkt_len[7:0]  <= byte_data;
              2'd1: pkt_len[15:8] <= {1'b0, byte_data[6:0]};
              2'd2: chan          <= byte_data;
              2'd3: begin
                if (pkt_len < 16'd4) begin
                  pkt_err <= 1'b1;
                  state   <= S_SKIP;
                end else if (pkt_len == 16'd4) begin
                  state <= S_IDLE;
                end else if (chan != CHANNEL) begin
                  state <= S_SKIP;
                end else begin
                  state <= S_RPT_ID;
                end
              end
            endcase
          end
          S_RPT_ID: begin
            byte_cnt <= cnt_inc;
            if (id_len == 5'd0) begin
              pkt_err <= 1'b1;
              state   <= S_SKIP;
            end else if (pkt_done) begin
              pkt_err <= 1'b1;
              state   <= S_IDLE;
            end else begin
              shadow[0] <= byte_data;
              rpt_id    <= byte_data;
              rpt_len   <= id_len;
              rpt_idx   <= 5'd1;
              state     <= S_RPT_BODY;
            end
          end
          S_RPT_BODY: begin
            byte_cnt                <= cnt_inc;
            shadow[rpt_idx[IW-1:0]] <= byte_data;
            rpt_idx                 <= rpt_idx + 5'd1;
            if (rpt_last) begin
              if (fwd) begin
                for (int unsigned i = 0; i < MAX_LEN; i++) begin
                  if (i < 32'(rpt_idx))       sensor_data[i] <= shadow[i];
                  else if (i == 32'(rpt_idx)) sensor_data[i] <= byte_data;
                  else                        sensor_data[i] <= '0;
                end
                sensor_report_id <= rpt_id;
                sensor_data_len  <= rpt_len;
                data_ready       <= 1'b1;
              end
              state <= pkt_done ? S_IDLE : S_RPT_ID;
            end else if (pkt_done) begin
              pkt_err <= 1'b1;
              state   <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
      if (frame_end && !frame_start) begin
        if (pkt_open && !(byte_valid && byte_leaves)) pkt_err <= 1'b1;
        state <= S_IDLE;
      end
    end
  end

`ifdef SHTP_SEQ_CHECK_EN
  logic [7:0] last_seq;
  logic       seq_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_seq <= '0;
      seq_vld  <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      if (byte_valid && (cur_st == S_HDR) && (cur_cnt == 16'd3) && (chan == CHANNEL)) begin
        seq_err  <= seq_vld && (byte_data != (last_seq + 8'd1));
        last_seq <= byte_data;
        seq_vld  <= 1'b1;
      end
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule
